// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// link timing constants and a width helper used for parameter defaults.
package uart_pkg;

    localparam int CLK_HZ       = 27000000;
    localparam int BAUD         = 115200;
    // One bit time at CLK_HZ / BAUD, rounded down (27e6 / 115200 = 234.375)
    localparam int DELAY_FRAMES = 234;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Width needed to hold values 0..value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the message sources, the arbiter and the TX
// bit engine. The slave side is the arbiter; the master side is everything
// around it (sources driving bytes in, TX engine returning tx_ready).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_ready,
        input  req_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_ready,
        output req_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the winner is the first requesting index
// found when scanning upward from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;

    // Rotate so bit j means requester (last+1+j) mod NUM_REQ, then keep the lowest set bit
    always_comb begin
        rot    = NUM_REQ'({req, req} >> (int'(last) + 1));
        winner = '0;
        any    = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                winner = GRANT_W'((int'(last) + 1 + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-serial TX engine among NUM_REQ message sources. A grant is
// held for a whole message (or until MAX_BYTES force a release), followed by
// an idle gap of GAP_CYCLES clocks before the next round-robin decision.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GRANT_W    = clog2_min1(NUM_REQ),
    parameter int GAP_CYCLES = DELAY_FRAMES,
    parameter int MAX_BYTES  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic [GRANT_W-1:0] grant_id,
    output logic               busy,
    output logic               burst_cut
);

    localparam int CNT_W = clog2_min1(MAX_BYTES + 1);
    localparam int GAP_W = clog2_min1(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MAX_BYTES > 0) ? MAX_BYTES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t         state;
    logic [GRANT_W-1:0] last_ptr;
    logic [GRANT_W-1:0] winner;
    logic               any_req;
    logic [CNT_W-1:0]   byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               tx_valid_c;
    logic [7:0]         tx_data_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               xfer;
    logic               msg_last;
    logic               limit_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req    (bus.req_valid),
        .last   (last_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // While sending, connect the grantee straight through to the TX engine
    always_comb begin
        tx_valid_c  = 1'b0;
        tx_data_c   = '0;
        req_ready_c = '0;
        if (state == ST_SEND) begin
            tx_valid_c = bus.req_valid[grant_id];
            if (tx_valid_c) begin
                tx_data_c = bus.req_data[{grant_id, 3'b000} +: 8];
            end
            req_ready_c[grant_id] = bus.tx_ready;
        end
    end

    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_data_c;
    assign bus.req_ready = req_ready_c;

    assign xfer      = tx_valid_c && bus.tx_ready;
    assign msg_last  = bus.req_last[grant_id];
    assign limit_hit = (MAX_BYTES > 0) && (byte_cnt == CNT_LIMIT);

    // Grant / send / gap sequencing with registered grant_id, busy and burst_cut
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_ptr  <= GRANT_W'(NUM_REQ - 1);
            grant_id  <= '0;
            busy      <= 1'b0;
            burst_cut <= 1'b0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            burst_cut <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (byte_cnt != '1) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (msg_last || limit_hit) begin
                            last_ptr  <= grant_id;
                            burst_cut <= !msg_last;
                            gap_cnt   <= '0;
                            if (GAP_CYCLES == 0) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven message sources, a cycle model of
// the arbitration rules compared against the DUT on every negedge, and
// directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GRANT_W = 2;
    localparam int GAP     = 234;
    localparam int MAXB    = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [GRANT_W-1:0] grant_id;
    logic               busy;
    logic               burst_cut;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .GRANT_W    (GRANT_W),
        .GAP_CYCLES (GAP),
        .MAX_BYTES  (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .burst_cut (burst_cut)
    );

    typedef struct {
        int cyc;
        int gid;
        int data;
    } xfer_t;

    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    logic [8:0]         src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] fire_n = '0;
    logic               tr_pulse = 1'b0;
    logic               tr_const = 1'b1;
    xfer_t              mon_q [$];
    xfer_t              mon_x;

    // Model of the arbitration rules: who owns the link, gap left, rotation pointer
    int   m_owner = -1;
    int   m_gap = 0;
    int   m_last = NUM_REQ - 1;
    int   m_cnt = 0;
    int   m_grant = 0;
    logic m_cut = 1'b0;

    logic               exp_valid;
    logic [7:0]         exp_data;
    logic [NUM_REQ-1:0] exp_ready;
    logic [8:0]         head;
    int                 t0;
    int                 exp_g [5] = '{0, 1, 2, 3, 0};
    int                 exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    // 10 ns clock
    initial forever #5 clk = ~clk;

    // Cycle counter, advanced on every rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int mon_cyc(input int i);
        return (i < mon_q.size()) ? mon_q[i].cyc : -1;
    endfunction

    function automatic int mon_gid(input int i);
        return (i < mon_q.size()) ? mon_q[i].gid : -1;
    endfunction

    function automatic int mon_data(input int i);
        return (i < mon_q.size()) ? mon_q[i].data : -1;
    endfunction

    // Present queue heads on the source ports, retiring bytes accepted last cycle
    task automatic apply_stimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire_n[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
            if (src_q[i].size() > 0) begin
                head = src_q[i][0];
                bus.req_valid[i]        = 1'b1;
                bus.req_data[8*i +: 8]  = head[7:0];
                bus.req_last[i]         = head[8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[8*i +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
        bus.tx_ready = tr_pulse ? ((cyc % 4) == 0) : tr_const;
    endtask

    task automatic push_byte(input int src, input logic [7:0] data, input logic last);
        src_q[src].push_back({last, data});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
        end
        tr_pulse = 1'b0;
        tr_const = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        mon_q.delete();
    endtask

    // Wait (bounded) until n transfers have been seen on the TX side
    task automatic wait_mon(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (mon_q.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timed out with %0d transfers, expected %0d", name, mon_q.size(), n);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic model_step();
        int c;
        m_cut = 1'b0;
        if (m_owner >= 0) begin
            if (bus.req_valid[m_owner] && bus.tx_ready) begin
                m_cnt++;
                if (bus.req_last[m_owner] || m_cnt == MAXB) begin
                    m_cut   = !bus.req_last[m_owner];
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = GAP;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && bus.req_valid[c]) begin
                    m_owner = c;
                    m_grant = c;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    // Source driver: one update just after every rising edge
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            apply_stimulus();
        end
    end

    // Advance the model on each edge, or clear it the moment reset asserts
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1;
            m_gap   = 0;
            m_last  = NUM_REQ - 1;
            m_cnt   = 0;
            m_grant = 0;
            m_cut   = 1'b0;
        end else begin
            model_step();
        end
    end

    // Mid-cycle: log transfers and compare every DUT output against the model
    initial forever begin
        @(negedge clk);
        fire_n = bus.req_valid & bus.req_ready;
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            mon_x.cyc  = cyc;
            mon_x.gid  = int'(grant_id);
            mon_x.data = int'(bus.tx_data);
            mon_q.push_back(mon_x);
        end
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ready = '0;
        if (m_owner >= 0) begin
            exp_valid = bus.req_valid[m_owner];
            if (exp_valid) begin
                exp_data = bus.req_data[8*m_owner +: 8];
            end
            exp_ready[m_owner] = bus.tx_ready;
        end
        check_output("cycle tx_valid", bus.tx_valid, exp_valid);
        check_output("cycle tx_data", bus.tx_data, exp_data);
        check_output("cycle req_ready", bus.req_ready, exp_ready);
        check_output("cycle grant_id", grant_id, m_grant);
        check_output("cycle busy", busy, (m_owner >= 0) || (m_gap > 0));
        check_output("cycle burst_cut", burst_cut, m_cut);
    end

    // Global time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // 1: reset values, single 3-byte message, latency and gap length
        do_reset();
        @(negedge clk);
        #1;
        check_output("reset tx_valid", bus.tx_valid, 1'b0);
        check_output("reset tx_data", bus.tx_data, 8'h00);
        check_output("reset req_ready", bus.req_ready, 4'b0000);
        check_output("reset grant_id", grant_id, 2'd0);
        check_output("reset busy", busy, 1'b0);
        check_output("reset burst_cut", burst_cut, 1'b0);
        t0 = cyc;
        push_byte(0, 8'h46, 1'b0);
        push_byte(0, 8'h61, 1'b0);
        push_byte(0, 8'h62, 1'b1);
        wait_mon(3, 20, "t1 transfers");
        check_output("t1 first latency", mon_cyc(0) - t0, 2);
        check_output("t1 last cycle", mon_cyc(2) - t0, 4);
        check_output("t1 byte0", mon_data(0), 8'h46);
        check_output("t1 byte1", mon_data(1), 8'h61);
        check_output("t1 byte2", mon_data(2), 8'h62);
        wait_cyc(t0 + 4 + GAP);
        check_output("t1 busy end of gap", busy, 1'b1);
        check_output("t1 grant held", grant_id, 2'd0);
        wait_cyc(t0 + 5 + GAP);
        check_output("t1 idle after gap", busy, 1'b0);

        // 2: all four requesting, 1-byte messages, rotation 0,1,2,3,0
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            push_byte(i, exp_d[i][7:0], 1'b1);
        end
        push_byte(0, 8'h14, 1'b1);
        wait_mon(5, 1300, "t2 transfers");
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("t2 grant %0d", i), mon_gid(i), exp_g[i]);
            check_output($sformatf("t2 data %0d", i), mon_data(i), exp_d[i]);
            check_output($sformatf("t2 spacing %0d", i), mon_cyc(i) - mon_cyc(0), (GAP + 2) * i);
        end

        // 3: grantee stalls 50 cycles mid-message while requester 2 waits
        do_reset();
        @(negedge clk);
        #1;
        push_byte(1, 8'hAA, 1'b0);
        push_byte(2, 8'h77, 1'b1);
        wait_mon(1, 20, "t3 first byte");
        repeat (50) begin
            @(negedge clk);
            #1;
        end
        check_output("t3 grant held", grant_id, 2'd1);
        check_output("t3 busy held", busy, 1'b1);
        push_byte(1, 8'h55, 1'b1);
        wait_mon(3, 600, "t3 transfers");
        check_output("t3 grant0", mon_gid(0), 1);
        check_output("t3 byte0", mon_data(0), 8'hAA);
        check_output("t3 grant1", mon_gid(1), 1);
        check_output("t3 byte1", mon_data(1), 8'h55);
        check_output("t3 stall length", mon_cyc(1) - mon_cyc(0), 51);
        check_output("t3 grant2", mon_gid(2), 2);
        check_output("t3 byte2", mon_data(2), 8'h77);
        check_output("t3 gap spacing", mon_cyc(2) - mon_cyc(1), GAP + 2);

        // 4: tx_ready high one cycle in four, other requester arrives mid-message
        do_reset();
        tr_pulse = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            push_byte(2, 8'(i + 1), i == 4);
        end
        wait_mon(1, 40, "t4 first byte");
        push_byte(0, 8'h99, 1'b1);
        wait_mon(6, 400, "t4 transfers");
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("t4 grant %0d", i), mon_gid(i), 2);
            check_output($sformatf("t4 data %0d", i), mon_data(i), i + 1);
            check_output($sformatf("t4 ready phase %0d", i), mon_cyc(i) % 4, 0);
        end
        check_output("t4 next grant", mon_gid(5), 0);
        check_output("t4 next data", mon_data(5), 8'h99);

        // 5: 20-byte stream without last, forced release at 16 bytes
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            push_byte(3, 8'(8'h20 + i), 1'b0);
        end
        wait_mon(16, 60, "t5 sixteen bytes");
        check_output("t5 no cut before edge", burst_cut, 1'b0);
        check_output("t5 byte15", mon_data(15), 8'h2F);
        @(negedge clk);
        #1;
        check_output("t5 cut pulse", burst_cut, 1'b1);
        check_output("t5 busy in gap", busy, 1'b1);
        push_byte(1, 8'hB1, 1'b1);
        @(negedge clk);
        #1;
        check_output("t5 cut one cycle", burst_cut, 1'b0);
        wait_mon(21, 1000, "t5 transfers");
        check_output("t5 lower rotation grant", mon_gid(16), 1);
        check_output("t5 lower rotation data", mon_data(16), 8'hB1);
        check_output("t5 regrant", mon_gid(17), 3);
        check_output("t5 resume data", mon_data(17), 8'h30);
        check_output("t5 final data", mon_data(20), 8'h33);

        // 6: asynchronous reset after the second byte of a message
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            push_byte(2, 8'(8'h61 + i), i == 4);
        end
        wait_mon(2, 20, "t6 two bytes");
        @(posedge clk);
        #3;
        check_output("t6 sending before reset", bus.tx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("t6 async tx_valid", bus.tx_valid, 1'b0);
        check_output("t6 async tx_data", bus.tx_data, 8'h00);
        check_output("t6 async req_ready", bus.req_ready, 4'b0000);
        check_output("t6 async grant_id", grant_id, 2'd0);
        check_output("t6 async busy", busy, 1'b0);
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
        end
        repeat (2) @(negedge clk);
        check_output("t6 partial abandoned", mon_q.size(), 2);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        t0 = cyc;
        push_byte(3, 8'hC3, 1'b1);
        wait_mon(3, 20, "t6 post-reset byte");
        check_output("t6 grant after reset", mon_gid(2), 3);
        check_output("t6 data after reset", mon_data(2), 8'hC3);
        check_output("t6 latency after reset", mon_cyc(2) - t0, 2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
